// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline MEM stage.
// Holds control-bit indices for the M and WB bundles carried in EX/MEM,
// the MEM-stage FSM encoding, and the MEM/WB payload struct.
package mips_pkg;

  // MEM control bundle bit positions
  localparam int M_BRANCH    = 2;
  localparam int M_READ      = 1;
  localparam int M_WRITE     = 0;

  // WB control bundle bit positions
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } mem_state_t;

  // Fields carried into MEM/WB alongside the load data
  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] alu_res;
    logic [4:0]  dest;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load            capture d (and mem_data_in when load_mem)
//   load_mem        with load, also capture the load data
//   bubble          squash: clear the WB control, keep the rest
//   d, mem_data_in  next contents
//   q, mem_data     current contents
// load wins over bubble when both are asserted.
module mem_wb_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        load_mem,
  input  logic        bubble,
  input  mem_wb_t     d,
  input  logic [31:0] mem_data_in,
  output mem_wb_t     q,
  output logic [31:0] mem_data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= '0;
      mem_data <= '0;
    end else if (load) begin
      q <= d;
      if (load_mem) mem_data <= mem_data_in;
    end else if (bubble) begin
      // A bubble only needs WB control cleared; data fields are don't-care
      q.wb <= '0;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline.
// Resolves branches from EX/MEM, runs loads/stores over a req/ack data
// memory handshake (IDLE -> BUSY -> RELEASE), stalls upstream while an
// access is outstanding, and feeds the MEM/WB register.
// Ports:
//   EX/MEM side : zeroIn, WB_In, M_In, PC_In, ALUResIn, storeDataIn, destIn
//   memory side : mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack
//   pipeline    : stall, pcSrc, branchTarget
//   MEM/WB side : WB_Out, memData_Out, ALUResOut, destOut
//   status      : align_err, bus_err (sticky until rst)
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        zeroIn,
  input  logic [1:0]  WB_In,
  input  logic [2:0]  M_In,
  input  logic [31:0] PC_In,
  input  logic [31:0] ALUResIn,
  input  logic [31:0] storeDataIn,
  input  logic [4:0]  destIn,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        pcSrc,
  output logic [31:0] branchTarget,
  output logic [1:0]  WB_Out,
  output logic [31:0] memData_Out,
  output logic [31:0] ALUResOut,
  output logic [4:0]  destOut,
  output logic        align_err,
  output logic        bus_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_t       state, next_state;
  logic [CNT_W-1:0] cnt;
  mem_wb_t          lat;          // EX/MEM payload of the access in flight
  mem_wb_t          in_payload, wb_d, wb_q;

  logic mem_op, misaligned;
  logic issue, timeout, use_lat, wb_load, wb_load_mem, wb_bubble;

  assign mem_op     = M_In[M_READ] | M_In[M_WRITE];
  assign misaligned = mem_op & (ALUResIn[1:0] != 2'b00);
  assign in_payload = '{wb: WB_In, alu_res: ALUResIn, dest: destIn};

  assign pcSrc        = M_In[M_BRANCH] & zeroIn & (state == IDLE);
  assign branchTarget = PC_In;

  always_comb begin
    next_state  = state;
    stall       = 1'b0;
    issue       = 1'b0;
    timeout     = 1'b0;
    use_lat     = 1'b0;
    wb_load     = 1'b0;
    wb_load_mem = 1'b0;
    wb_bubble   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && !misaligned) begin
          stall      = 1'b1;
          issue      = 1'b1;
          wb_bubble  = 1'b1;
          next_state = BUSY;
        end else if (misaligned) begin
          wb_bubble = 1'b1;
        end else begin
          wb_load = 1'b1;
        end
      end
      BUSY: begin
        stall = 1'b1;
        // ack beats timeout when both land on the last allowed cycle
        if (mem_ack) begin
          use_lat     = 1'b1;
          wb_load     = 1'b1;
          wb_load_mem = ~mem_we;
          next_state  = RELEASE;
        end else if (cnt == CNT_LAST) begin
          timeout    = 1'b1;
          wb_bubble  = 1'b1;
          next_state = RELEASE;
        end else begin
          wb_bubble = 1'b1;
        end
      end
      // One unstalled cycle lets EX/MEM move past the finished op so it
      // is not re-issued.
      RELEASE: begin
        wb_bubble  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign wb_d = use_lat ? lat : in_payload;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      align_err <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state <= next_state;
      if (issue) begin
        mem_req   <= 1'b1;
        mem_we    <= M_In[M_WRITE] & ~M_In[M_READ];
        mem_addr  <= ALUResIn;
        mem_wdata <= storeDataIn;
        lat       <= in_payload;
        cnt       <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + CNT_W'(1);
        if (mem_ack || timeout) mem_req <= 1'b0;
      end
      if (state == IDLE && misaligned) align_err <= 1'b1;
      if (timeout) bus_err <= 1'b1;
    end
  end

  mem_wb_reg u_mem_wb (
    .clk         (clk),
    .rst         (rst),
    .load        (wb_load),
    .load_mem    (wb_load_mem),
    .bubble      (wb_bubble),
    .d           (wb_d),
    .mem_data_in (mem_rdata),
    .q           (wb_q),
    .mem_data    (memData_Out)
  );

  assign WB_Out    = wb_q.wb;
  assign ALUResOut = wb_q.alu_res;
  assign destOut   = wb_q.dest;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage. Each operation is modelled at
// transaction level: what MEM/WB and the flags must hold afterwards and how
// many stall cycles the access costs.
module tb_mem_access_stage;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        zeroIn;
  logic [1:0]  WB_In;
  logic [2:0]  M_In;
  logic [31:0] PC_In, ALUResIn, storeDataIn;
  logic [4:0]  destIn;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        stall, pcSrc;
  logic [31:0] branchTarget;
  logic [1:0]  WB_Out;
  logic [31:0] memData_Out, ALUResOut;
  logic [4:0]  destOut;
  logic        align_err, bus_err;

  int checks   = 0;
  int failures = 0;

  // reference MEM/WB and flag state
  logic [1:0]  e_wb;
  logic [31:0] e_alu, e_mem;
  logic [4:0]  e_dest;
  logic        e_align, e_bus;

  mem_access_stage #(.TIMEOUT(TMO), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .zeroIn(zeroIn), .WB_In(WB_In), .M_In(M_In),
    .PC_In(PC_In), .ALUResIn(ALUResIn), .storeDataIn(storeDataIn),
    .destIn(destIn), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .stall(stall), .pcSrc(pcSrc),
    .branchTarget(branchTarget), .WB_Out(WB_Out), .memData_Out(memData_Out),
    .ALUResOut(ALUResOut), .destOut(destOut), .align_err(align_err),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_wb"},    32'(WB_Out),    32'(e_wb));
    chk({tag, "_mem"},   memData_Out,    e_mem);
    chk({tag, "_align"}, 32'(align_err), 32'(e_align));
    chk({tag, "_bus"},   32'(bus_err),   32'(e_bus));
  endtask

  task automatic do_alu(input logic [1:0] wb, input logic [31:0] alu, input logic [4:0] dest,
                        input logic br, input logic z, input logic [31:0] pc);
    WB_In = wb; M_In = {br, 2'b00}; ALUResIn = alu; destIn = dest;
    zeroIn = z; PC_In = pc; storeDataIn = $urandom; mem_ack = 1'b0;
    #1;
    chk("alu_stall",   32'(stall),   0);
    chk("alu_noreq",   32'(mem_req), 0);
    chk("alu_pcsrc",   32'(pcSrc),   32'(br & z));
    chk("alu_btarget", branchTarget, pc);
    tick();
    e_wb = wb; e_alu = alu; e_dest = dest;
    chk("alu_res",  ALUResOut,     e_alu);
    chk("alu_dest", 32'(destOut),  32'(e_dest));
    chk_state("alu");
  endtask

  // ack_at: BUSY cycle index (0 = first) carrying mem_ack; >= TMO means none
  task automatic do_mem(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] wb, input logic [4:0] dest,
                        input int ack_at, input logic [31:0] rdata);
    logic        we;
    logic        acked, tmo;
    int          stalls;
    logic [31:0] r;
    we = wr & ~rd; acked = 1'b0; tmo = 1'b0; stalls = 0;
    WB_In = wb; M_In = {1'b0, rd, wr}; ALUResIn = addr; destIn = dest;
    storeDataIn = wdata; zeroIn = 1'b0; mem_ack = 1'b0;
    #1;
    if (addr[1:0] != 2'b00) begin
      chk("mis_stall", 32'(stall), 0);
      tick();
      e_wb = 2'b00; e_align = 1'b1;
      chk("mis_noreq", 32'(mem_req), 0);
      chk_state("mis");
      return;
    end
    chk("issue_stall", 32'(stall), 1);
    stalls = 1;
    tick();
    chk("req",   32'(mem_req), 1);
    chk("we",    32'(mem_we),  32'(we));
    chk("addr",  mem_addr,     addr);
    if (we) chk("wdata", mem_wdata, wdata);
    // EX/MEM contents must not matter while the access is in flight
    r = $urandom; WB_In = r[1:0]; destIn = r[6:2];
    ALUResIn = $urandom; storeDataIn = $urandom; M_In = 3'b111; zeroIn = 1'b1;
    for (int k = 0; !acked && !tmo; k++) begin
      mem_ack   = (k == ack_at);
      mem_rdata = mem_ack ? rdata : $urandom;
      #1;
      chk("busy_stall",  32'(stall),   1);
      chk("busy_req",    32'(mem_req), 1);
      chk("busy_addr",   mem_addr,     addr);
      chk("busy_bubble", 32'(WB_Out),  0);
      chk("busy_pcsrc",  32'(pcSrc),   0);
      stalls++;
      if (mem_ack) acked = 1'b1;
      else if (k == TMO - 1) tmo = 1'b1;
      tick();
    end
    if (acked) begin
      e_wb = wb; e_alu = addr; e_dest = dest;
      if (rd) e_mem = rdata;
    end else begin
      e_bus = 1'b1;
    end
    chk("stall_cycles", 32'(stalls), acked ? 32'(ack_at + 2) : 32'(TMO + 1));
    // RELEASE: a stray ack and a fresh aligned load must both be ignored
    M_In = 3'b010; ALUResIn = 32'h0000_0500; mem_ack = 1'b1; mem_rdata = $urandom;
    #1;
    chk("rel_stall", 32'(stall),   0);
    chk("rel_req",   32'(mem_req), 0);
    if (acked) begin
      chk("rel_res",  ALUResOut,    e_alu);
      chk("rel_dest", 32'(destOut), 32'(e_dest));
    end
    chk_state("rel");
    tick();
    e_wb = 2'b00;
    chk("post_noreq", 32'(mem_req), 0);
    chk_state("post");
    mem_ack = 1'b0; M_In = 3'b000;
  endtask

  initial begin
    logic [31:0] r, a;
    int sel;
    rst = 1'b1; zeroIn = 1'b0; WB_In = '0; M_In = '0; PC_In = '0;
    ALUResIn = '0; storeDataIn = '0; destIn = '0; mem_rdata = '0; mem_ack = 1'b0;
    e_wb = '0; e_alu = '0; e_mem = '0; e_dest = '0; e_align = 1'b0; e_bus = 1'b0;
    tick(); tick();
    chk("rst_req",   32'(mem_req), 0);
    chk("rst_we",    32'(mem_we),  0);
    chk("rst_addr",  mem_addr,     0);
    chk("rst_wdata", mem_wdata,    0);
    chk("rst_res",   ALUResOut,    0);
    chk("rst_dest",  32'(destOut), 0);
    chk_state("rst");
    rst = 1'b0;

    // directed
    do_alu(2'b10, 32'h0000_1234, 5'd7, 1'b0, 1'b0, 32'h0);
    do_mem(1'b1, 1'b0, 32'h0000_0100, 32'h0, 2'b11, 5'd9, 3, 32'hDEAD_BEEF);
    do_mem(1'b0, 1'b1, 32'h0000_0200, 32'h0000_CAFE, 2'b00, 5'd3, 0, 32'h0);
    do_alu(2'b00, 32'h0, 5'd0, 1'b1, 1'b1, 32'h0000_0040);
    do_alu(2'b00, 32'h0, 5'd0, 1'b1, 1'b0, 32'h0000_0040);
    do_mem(1'b1, 1'b0, 32'h0000_0102, 32'h0, 2'b11, 5'd4, 0, 32'h0);
    do_mem(1'b1, 1'b1, 32'h0000_0104, 32'h1111_1111, 2'b11, 5'd5, 1, 32'h2222_2222);
    do_mem(1'b1, 1'b0, 32'h0000_0400, 32'h0, 2'b11, 5'd6, 99, 32'h0);

    // randomized mix
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 3);
      r = $urandom;
      a = $urandom;
      case (sel)
        0: do_alu(r[1:0], a, r[6:2], r[7], r[8], $urandom);
        1: do_mem(1'b1, r[9], {a[31:2], 2'b00}, $urandom, r[1:0], r[6:2],
                  $urandom_range(0, 5), $urandom);
        2: do_mem(1'b0, 1'b1, {a[31:2], 2'b00}, $urandom, r[1:0], r[6:2],
                  $urandom_range(0, 5), $urandom);
        default: do_mem(r[10], ~r[10], {a[31:2], (r[12:11] == 2'b00) ? 2'b01 : r[12:11]},
                        $urandom, r[1:0], r[6:2], 0, $urandom);
      endcase
    end

    // reset in the middle of an access
    WB_In = 2'b11; M_In = 3'b010; ALUResIn = 32'h0000_0300; destIn = 5'd1;
    tick(); tick();
    rst = 1'b1;
    tick();
    e_wb = '0; e_alu = '0; e_mem = '0; e_dest = '0; e_align = 1'b0; e_bus = 1'b0;
    chk("mrst_req",  32'(mem_req), 0);
    chk("mrst_addr", mem_addr,     0);
    chk("mrst_res",  ALUResOut,    0);
    chk_state("mrst");
    rst = 1'b0; WB_In = '0; M_In = '0; ALUResIn = '0; destIn = '0;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_req", 32'(mem_req), 0);
    chk_state("late_ack");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
